// File: rtl/dm_access_unit_pkg.sv
// Shared size codes, FSM states and address-width default for the data-memory access unit.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package dm_access_unit_pkg;

    localparam int DM_AW_DEF = 6;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_X = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_WRITE  = 2'b10,
        ST_RESP   = 2'b11
    } state_e;

    // True for an illegal size or an access not aligned to its own size.
    function automatic logic req_bad(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            SZ_W:    return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dm_access_unit_if.sv
// Request/response bundle between the MEM stage and the data-memory access unit.
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready and rsp_valid/rsp_ready handshakes; master = requester, slave = unit.
interface dm_access_unit_if
    import dm_access_unit_pkg::*;
#(
    parameter int DM_AW = DM_AW_DEF
) ();
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [1:0]       req_size;
    logic             req_unsigned;
    logic [DM_AW+1:0] req_addr;
    logic [31:0]      req_wdata;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_rdata;
    logic             rsp_err;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dm_lane_align.sv
// Byte/halfword lane extraction with sign/zero extension (load) and lane merge into an old word (store).
// Latency: combinational.
// Backpressure: none.
// Ports: word = memory word, wdata = store data, size/off = access size and byte offset,
//        uns = zero-extend loads; ld_data = extended load value, st_data = merged store word.
module dm_lane_align
    import dm_access_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        uns,
    output logic [31:0] ld_data,
    output logic [31:0] st_data
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word[7:0];
        case (off)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase
        half_v = off[1] ? word[31:16] : word[15:0];

        case (size)
            SZ_B:    ld_data = {{24{~uns & byte_v[7]}}, byte_v};
            SZ_H:    ld_data = {{16{~uns & half_v[15]}}, half_v};
            default: ld_data = word;
        endcase

        st_data = word;
        case (size)
            SZ_B: begin
                case (off)
                    2'd0:    st_data[7:0]   = wdata[7:0];
                    2'd1:    st_data[15:8]  = wdata[7:0];
                    2'd2:    st_data[23:16] = wdata[7:0];
                    default: st_data[31:24] = wdata[7:0];
                endcase
            end
            SZ_H: begin
                if (off[1]) st_data[31:16] = wdata[15:0];
                else        st_data[15:0]  = wdata[15:0];
            end
            default: st_data = wdata;
        endcase
    end
endmodule

// File: rtl/dm_access_unit.sv
// Load/store initiator for a word-wide data memory; sub-word stores via read-modify-write.
// Latency: response 1 cycle after accept for errors, 2 for loads/word stores, 3 for byte/half stores.
// Backpressure: one request outstanding; req_ready only in IDLE, response held until rsp_ready.
// Ports: clk_dm/rst_n; bus (slave side of dm_access_unit_if) carries request and response;
//        Mem_Write/DM_Addr/M_W_Data drive the memory, M_R_Data is its combinational read data.
module dm_access_unit
    import dm_access_unit_pkg::*;
#(
    parameter int DM_AW = DM_AW_DEF
) (
    input  logic             clk_dm,
    input  logic             rst_n,
    dm_access_unit_if.slave  bus,
    output logic             Mem_Write,
    output logic [DM_AW-1:0] DM_Addr,
    output logic [31:0]      M_W_Data,
    input  logic [31:0]      M_R_Data
);
    state_e           state_q, state_d;
    logic             lat_write, lat_uns, rsp_err_q;
    logic [1:0]       lat_size;
    logic [DM_AW+1:0] lat_addr;
    logic [31:0]      lat_wdata, merge_q, rdata_q;
    logic [31:0]      ld_data, st_data;
    logic             accept, bad;

    assign accept = (state_q == ST_IDLE) && bus.req_valid;
    assign bad    = req_bad(bus.req_size, bus.req_addr[1:0]);

    dm_lane_align u_align (
        .word    (M_R_Data),
        .wdata   (lat_wdata),
        .size    (lat_size),
        .off     (lat_addr[1:0]),
        .uns     (lat_uns),
        .ld_data (ld_data),
        .st_data (st_data)
    );

    always_ff @(posedge clk_dm or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        Mem_Write = 1'b0;
        case (state_q)
            ST_IDLE:   if (bus.req_valid) state_d = bad ? ST_RESP : ST_ACCESS;
            ST_ACCESS: begin
                // Word stores go straight to memory; sub-word stores need the old word first.
                if (lat_write && lat_size != SZ_W) begin
                    state_d = ST_WRITE;
                end else begin
                    Mem_Write = lat_write;
                    state_d   = ST_RESP;
                end
            end
            ST_WRITE: begin
                Mem_Write = 1'b1;
                state_d   = ST_RESP;
            end
            default:   if (bus.rsp_ready) state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_dm or negedge rst_n) begin
        if (!rst_n) begin
            lat_write <= 1'b0;
            lat_uns   <= 1'b0;
            lat_size  <= 2'b00;
            lat_addr  <= '0;
            lat_wdata <= '0;
            merge_q   <= '0;
            rdata_q   <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            if (accept) begin
                lat_write <= bus.req_write;
                lat_uns   <= bus.req_unsigned;
                lat_size  <= bus.req_size;
                lat_addr  <= bus.req_addr;
                lat_wdata <= bus.req_wdata;
                rdata_q   <= '0;
                rsp_err_q <= bad;
            end
            if (state_q == ST_ACCESS) begin
                if (!lat_write) rdata_q <= ld_data;
                merge_q <= st_data;
            end
        end
    end

    // Memory-side outputs come only from registered state so req_* never reaches the array.
    assign DM_Addr       = lat_addr[DM_AW+1:2];
    assign M_W_Data      = (state_q == ST_WRITE) ? merge_q : lat_wdata;
    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_dm_access_unit.sv
// Self-checking bench for dm_access_unit: directed scenarios then random traffic vs a byte-level model.
// Latency: checks response cycle count per request class.
// Backpressure: exercises a held response with rsp_ready low and an ignored competing request.
module tb_dm_access_unit;
    import dm_access_unit_pkg::*;

    logic        clk_dm = 1'b0;
    logic        rst_n;
    logic        Mem_Write;
    logic [5:0]  DM_Addr;
    logic [31:0] M_W_Data;
    logic [31:0] M_R_Data;

    dm_access_unit_if bus ();

    dm_access_unit dut (
        .clk_dm    (clk_dm),
        .rst_n     (rst_n),
        .bus       (bus),
        .Mem_Write (Mem_Write),
        .DM_Addr   (DM_Addr),
        .M_W_Data  (M_W_Data),
        .M_R_Data  (M_R_Data)
    );

    always #5 clk_dm = ~clk_dm;

    // Memory device seen by the DUT.
    logic [31:0] mem [0:63];
    int          wr_count = 0;
    logic [31:0] last_wdata = '0;
    logic [5:0]  last_waddr = '0;

    assign M_R_Data = mem[DM_Addr];

    always @(posedge clk_dm) begin
        if (Mem_Write === 1'b1) begin
            mem[DM_Addr] <= M_W_Data;
            wr_count     <= wr_count + 1;
            last_wdata   <= M_W_Data;
            last_waddr   <= DM_Addr;
        end
    end

    // Reference: plain byte-addressed memory.
    logic [7:0] ref_mem [0:255];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic wr, input logic [1:0] sz, input logic uns, input logic [7:0] a,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd,
                         output logic err, output int nw);
        int     nbytes;
        longint v;
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        err    = (sz == 2'd3) || ((int'(a) % nbytes) != 0);
        rd     = '0;
        nw     = 0;
        if (err) begin
            lat = 1;
        end else if (!wr) begin
            v = 0;
            for (int i = 0; i < nbytes; i++) v = v | (longint'(ref_mem[int'(a) + i]) << (8 * i));
            if (!uns && v[8 * nbytes - 1]) v = v - (longint'(1) << (8 * nbytes));
            rd  = v[31:0];
            lat = 2;
        end else begin
            for (int i = 0; i < nbytes; i++) ref_mem[int'(a) + i] = 8'((wd >> (8 * i)) & 32'hFF);
            lat = (nbytes == 4) ? 2 : 3;
            nw  = 1;
        end
    endtask

    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns, input logic [7:0] a,
                          input logic [31:0] wd, output logic [31:0] got);
        int          lat, nw, w, cyc, wc0;
        logic [31:0] rd;
        logic        err, seen;
        model(wr, sz, uns, a, wd, lat, rd, err, nw);
        w = 0;
        while (bus.req_ready !== 1'b1 && w < 20) begin
            @(posedge clk_dm); #1; w++;
        end
        check("req_ready_before", 32'(bus.req_ready), 32'd1);
        bus.req_write    = wr;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        bus.req_valid    = 1'b1;
        bus.rsp_ready    = 1'b1;
        wc0  = wr_count;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 8) begin
            @(posedge clk_dm); #1;
            bus.req_valid = 1'b0;
            cyc++;
            if (bus.rsp_valid === 1'b1) seen = 1'b1;
        end
        check("rsp_latency", 32'(cyc), 32'(lat));
        check("rsp_rdata", bus.rsp_rdata, rd);
        check("rsp_err", 32'(bus.rsp_err), 32'(err));
        got = bus.rsp_rdata;
        @(posedge clk_dm); #1;
        check("rsp_released", 32'(bus.rsp_valid), 32'd0);
        check("mem_write_count", 32'(wr_count - wc0), 32'(nw));
    endtask

    initial begin
        logic [31:0] got;
        int          wc0;
        logic [7:0]  a;

        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        int          wc0;
        logic [7:0]  a;
        logic [1:0]  sz;

        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            for (int j = 0; j < 4; j++) ref_mem[4 * i + j] = mem[i][8 * j +: 8];
        end
        rst_n            = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.rsp_ready    = 1'b1;

        // Reset state
        #2;
        check("rst_mem_write", 32'(Mem_Write), 32'd0);
        check("rst_dm_addr", 32'(DM_Addr), 32'd0);
        check("rst_m_w_data", M_W_Data, 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        @(posedge clk_dm); @(posedge clk_dm); #1;
        rst_n = 1'b1;
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);

        // Word store then word load
        do_req(1'b1, SZ_W, 1'b0, 8'h08, 32'hDEADBEEF, got);
        check("wstore_addr", 32'(last_waddr), 32'd2);
        check("wstore_data", last_wdata, 32'hDEADBEEF);
        do_req(1'b0, SZ_W, 1'b0, 8'h08, 32'h0, got);
        check("wload_data", got, 32'hDEADBEEF);

        // Sub-word loads
        do_req(1'b0, SZ_B, 1'b0, 8'h0B, 32'h0, got);
        check("lb_signed", got, 32'hFFFFFFDE);
        do_req(1'b0, SZ_B, 1'b1, 8'h0B, 32'h0, got);
        check("lb_unsigned", got, 32'h000000DE);
        do_req(1'b0, SZ_H, 1'b0, 8'h08, 32'h0, got);
        check("lh_signed", got, 32'hFFFFBEEF);

        // Byte store via read-modify-write
        do_req(1'b1, SZ_B, 1'b0, 8'h09, 32'h00000055, got);
        check("sb_merged", last_wdata, 32'hDEAD55EF);
        do_req(1'b0, SZ_W, 1'b0, 8'h08, 32'h0, got);
        check("sb_readback", got, 32'hDEAD55EF);

        // Error cases
        do_req(1'b1, SZ_H, 1'b0, 8'h0B, 32'h0000AAAA, got);
        do_req(1'b0, SZ_W, 1'b0, 8'h0A, 32'h0, got);
        do_req(1'b0, SZ_X, 1'b0, 8'h00, 32'h0, got);
        check("err_mem_unchanged", mem[2], 32'hDEAD55EF);

        // Held response with a competing request
        bus.req_write = 1'b0; bus.req_size = SZ_W; bus.req_unsigned = 1'b0;
        bus.req_addr = 8'h08; bus.req_wdata = '0;
        bus.rsp_ready = 1'b0; bus.req_valid = 1'b1;
        @(posedge clk_dm); #1;
        bus.req_valid = 1'b0;
        @(posedge clk_dm); #1;
        check("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        bus.req_write = 1'b1; bus.req_addr = 8'h10; bus.req_wdata = 32'h12345678;
        bus.req_valid = 1'b1;
        wc0 = wr_count;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_dm); #1;
            check("stall_hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("stall_hold_rdata", bus.rsp_rdata, 32'hDEAD55EF);
            check("stall_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk_dm); #1;
        check("stall_release", 32'(bus.rsp_valid), 32'd0);
        check("stall_no_write", 32'(wr_count - wc0), 32'd0);
        do_req(1'b0, SZ_W, 1'b0, 8'h10, 32'h0, got);

        // Reset during WRITE of a byte store
        wc0 = wr_count;
        bus.req_write = 1'b1; bus.req_size = SZ_B; bus.req_unsigned = 1'b0;
        bus.req_addr = 8'h09; bus.req_wdata = 32'h000000AA; bus.req_valid = 1'b1;
        @(posedge clk_dm); #1;
        bus.req_valid = 1'b0;
        check("rmw_access_no_write", 32'(Mem_Write), 32'd0);
        @(posedge clk_dm); #1;
        check("rmw_write_phase", 32'(Mem_Write), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rmw_reset_drop", 32'(Mem_Write), 32'd0);
        @(posedge clk_dm); #1;
        rst_n = 1'b1;
        #1;
        check("rmw_reset_ready", 32'(bus.req_ready), 32'd1);
        check("rmw_reset_no_write", 32'(wr_count - wc0), 32'd0);
        do_req(1'b0, SZ_W, 1'b0, 8'h08, 32'h0, got);
        check("rmw_reset_word", got, 32'hDEAD55EF);

        // Random traffic
        for (int n = 0; n < 150; n++) begin
            sz = 2'($urandom_range(0, 3));
            a  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == SZ_H) a[0] = 1'b0;
                if (sz == SZ_W) a[1:0] = 2'b00;
            end
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, got);
        end

        for (int i = 0; i < 64; i++)
            check("final_mem", mem[i], {ref_mem[4 * i + 3], ref_mem[4 * i + 2], ref_mem[4 * i + 1], ref_mem[4 * i]});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
